shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
Parametrised shared-memory controller for the manycore array. Replaces per-core combinational access to shared data with one arbitrated, registered shared memory serving NUM_CORES single-cycle cores. Each core presents its shared-access request and receives a stall that freezes its PC until its access completes. Sits between the core array and the shared data RAM, which is held inside this block.

Parameters:
NUM_CORES, 4, number of requesting cores (2..16)
DATA_W, 32, data word width
ADDR_W, 32, byte address width per core
DEPTH, 256, shared memory depth in words (power of 2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
req  input  NUM_CORES  per-core shared access request (core's sharedMEM)
rd  input  NUM_CORES  per-core read strobe
wr  input  NUM_CORES  per-core write strobe
addr  input  NUM_CORES*ADDR_W  per-core byte address; core i at [i*ADDR_W +: ADDR_W]
wdata  input  NUM_CORES*DATA_W  per-core write data
rdata  output  NUM_CORES*DATA_W  per-core registered read data
stall  output  NUM_CORES  per-core hold-PC / hold-writeback
grant  output  NUM_CORES  one-hot registered owner of current access
busy  output  1  high when state is not IDLE

Behaviour:
- Clock is clk; reset is synchronous and active-high, named reset.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req set, select winner by round-robin starting at pointer ptr; latch winner index, word address, wdata, rd, wr; grant becomes one-hot winner; go to ACCESS. Otherwise stay in IDLE with grant=0.
- ACCESS: wr: mem[word] <= wdata at this edge. rd: rdata slice of winner <= mem[word]. Go to DONE.
- DONE: winner's access is complete; ptr <= (winner+1) mod NUM_CORES; grant <= 0; go to IDLE.
- stall[i] = req[i] & ~(state==DONE & grant[i]); combinational. A requesting core is released for exactly one cycle, the DONE cycle, and commits on that edge.
- Minimum latency: request in cycle 0, release in cycle 2; 3 cycles per access. Back-to-back service of another core starts at the IDLE cycle after DONE.
- Word address = addr[log2(DEPTH)+1 : 2]; higher bits ignored (wrap modulo DEPTH).
- rd and wr both set: write performed, rdata not updated.
- req with neither rd nor wr: no-op access, still completes through DONE.
- rdata slices hold their value until the next read by the same core; other cores' slices are unaffected.
- A core that drops req during ACCESS or DONE still has its access completed. Write is performed; read result is stored but ignored.
- Fairness: with all cores requesting continuously, each core is granted once per NUM_CORES accesses.
- Reset values: state IDLE, ptr 0, grant 0, busy 0, all rdata 0. Stall follows req, so stall equals req in the reset cycle.
- Reset asserted during ACCESS takes priority: any pending write is not performed. Memory contents are not cleared by reset.

Optional Feature:
SHMEM_FIXED_PRIO_EN defined: fixed priority, lowest core index wins; ptr is not used and stays 0. Not defined: round-robin as above.

Test Plan:
- Single write then read: core 1 writes 0xDEADBEEF to addr 0x80, then reads 0x80. stall[1] is high for 2 cycles per access; rdata[1] = 0xDEADBEEF; other rdata stay 0.
- Contention with round-robin: all 4 cores request reads at once from reset. Grant order is 0,1,2,3. Core 3 is released at cycle 11; each core's stall stays high until its own DONE.
- Pointer rotation: after core 2 is served, cores 0 and 3 request together. Core 3 is granted first. With SHMEM_FIXED_PRIO_EN defined, core 0 is granted first.
- Wrap and rd+wr: write 0x55 to addr 4*DEPTH+8, then read addr 8, which returns 0x55. An access with rd=wr=1 writes memory and leaves rdata unchanged.
- Reset mid-access: core 0 writes 0x1234 to addr 0x10 and reset is asserted in the ACCESS cycle. A later read of 0x10 returns the prior value. After reset, state is IDLE, grant=0 and ptr=0.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// ---------------------------------------------------------------------------
// shared_mem_arbiter
//
// A single-ported shared data RAM that serves NUM_CORES single-cycle cores
// through one arbitrated, registered access path. Only one access is in
// flight at a time. Each access takes three cycles: IDLE (arbitrate),
// ACCESS (RAM read/write), DONE (release the winner). Each core sees a
// combinational stall that keeps its PC frozen until its own DONE cycle.
//
// Ports
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   req    : [NUM_CORES]        per-core shared access request
//   rd     : [NUM_CORES]        per-core read strobe
//   wr     : [NUM_CORES]        per-core write strobe
//   addr   : [NUM_CORES*ADDR_W] per-core byte address, core i at [i*ADDR_W +: ADDR_W]
//   wdata  : [NUM_CORES*DATA_W] per-core write data
//   rdata  : [NUM_CORES*DATA_W] per-core registered read data
//   stall  : [NUM_CORES]        per-core hold-PC / hold-writeback
//   grant  : [NUM_CORES]        one-hot registered owner of the current access
//   busy   : 1                  state is not IDLE
//
// Build option
//   SHMEM_FIXED_PRIO_EN : when defined, the lowest requesting core index
//                         always wins and the rotation pointer stays 0.
//                         When undefined, arbitration is round-robin.
// ---------------------------------------------------------------------------

// Per-core slice: holds that core's read-data register and forms its stall.
module shared_mem_arbiter_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              release_now,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] rdata,
  output logic              stall
);

  always_ff @(posedge clk) begin
    if (reset)     rdata <= '0;
    else if (load) rdata <= load_data;
  end

  // Released only in the DONE cycle of this core's own access.
  assign stall = req & ~release_now;

endmodule

module shared_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        rd,
  input  logic [NUM_CORES-1:0]        wr,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES*DATA_W-1:0] rdata,
  output logic [NUM_CORES-1:0]        stall,
  output logic [NUM_CORES-1:0]        grant,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam int WA_W  = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // Everything about the winning request, captured at arbitration time so
  // the core may change its inputs while the access completes.
  typedef struct packed {
    logic [IDX_W-1:0]  win;
    logic [WA_W-1:0]   word;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic              wr;
  } acc_t;

  logic [1:0]           state;
  logic [IDX_W-1:0]     ptr;
  logic [NUM_CORES-1:0] grant_q;
  acc_t                 acc;

  logic [NUM_CORES-1:0][WA_W-1:0]   word_in;
  logic [NUM_CORES-1:0][DATA_W-1:0] wdata_in;
  logic [NUM_CORES-1:0][DATA_W-1:0] rdata_arr;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_q;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   ptr_nxt;

  // Only the word-index bits of each address are used; the byte offset and
  // the bits above the RAM depth are deliberately dropped (address wraps).
  logic unused_addr;
  assign unused_addr = ^addr;

  assign wdata_in = wdata;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_word
    assign word_in[i] = addr[i*ADDR_W + 2 +: WA_W];
  end

  // Scan from ptr upward, wrapping at NUM_CORES; the first requester wins.
  // With ptr pinned at 0 the same scan gives lowest-index priority.
  always_comb begin
    logic [IDX_W:0] sum;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_CORES)) sum = sum - (IDX_W+1)'(NUM_CORES);
      if (!win_found && req[sum[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[IDX_W-1:0];
      end
    end
  end

  // Pointer moves to the core after the one just served.
  always_comb begin
    ptr_nxt = {1'b0, acc.win} + 1'b1;
    if (ptr_nxt >= (IDX_W+1)'(NUM_CORES)) ptr_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      grant_q <= '0;
      acc     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          grant_q <= '0;
          if (win_found) begin
            acc.win   <= win_idx;
            acc.word  <= word_in[win_idx];
            acc.wdata <= wdata_in[win_idx];
            acc.rd    <= rd[win_idx];
            acc.wr    <= wr[win_idx];
            grant_q   <= NUM_CORES'(1) << win_idx;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: state <= S_DONE;
        S_DONE: begin
`ifdef SHMEM_FIXED_PRIO_EN
          ptr     <= '0;
`else
          ptr     <= ptr_nxt[IDX_W-1:0];
`endif
          grant_q <= '0;
          state   <= S_IDLE;
        end
        default: begin
          grant_q <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // RAM has no reset; reset only suppresses a write caught in ACCESS.
  always_ff @(posedge clk) begin
    if (!reset && state == S_ACCESS && acc.wr) mem[acc.word] <= acc.wdata;
  end

  assign mem_q = mem[acc.word];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    logic load;
    // A combined rd+wr access is treated as a write only.
    assign load = (state == S_ACCESS) && acc.rd && !acc.wr &&
                  (acc.win == IDX_W'(i));
    shared_mem_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
      .clk         (clk),
      .reset       (reset),
      .req         (req[i]),
      .release_now ((state == S_DONE) && grant_q[i]),
      .load        (load),
      .load_data   (mem_q),
      .rdata       (rdata_arr[i]),
      .stall       (stall[i])
    );
  end

  assign rdata = rdata_arr;
  assign grant = grant_q;
  assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shared_mem_arbiter
//
// Directed bench for shared_mem_arbiter with NUM_CORES=4, DATA_W=32,
// ADDR_W=32, DEPTH=256. Inputs change 1 time unit after a rising edge and
// outputs are sampled 1 time unit later, well clear of either clock edge.
// Honours SHMEM_FIXED_PRIO_EN for the arbitration-order expectation.
// ---------------------------------------------------------------------------
module tb_shared_mem_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int D  = 256;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, rd, wr;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*DW-1:0] rdata;
  logic [N-1:0]    stall, grant;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shared_mem_arbiter #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .stall (stall),
    .grant (grant),
    .busy  (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int c, input logic q, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    req[c] = q;
    rd[c]  = r;
    wr[c]  = w;
    addr[c*AW +: AW]  = a;
    wdata[c*DW +: DW] = d;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req = '0; rd = '0; wr = '0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // One uncontended access by core c, entered and left in an IDLE cycle.
  task automatic single(input int c, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    logic [N-1:0] oh;
    oh    = '0;
    oh[c] = 1'b1;
    set_core(c, 1'b1, r, w, a, d);
    #1;
    chk("idle_stall", stall, oh);
    chk("idle_grant", grant, 0);
    tick;
    chk("access_grant", grant, oh);
    chk("access_busy", busy, 1);
    chk("access_stall", stall, oh);
    tick;
    chk("done_stall", stall, 0);
    chk("done_grant", grant, oh);
    set_core(c, 1'b0, 1'b0, 1'b0, a, d);
    tick;
    chk("back_idle", {busy, grant}, 0);
  endtask

  initial begin
    logic [N-1:0] eg, es;
    int s, p;

    // Reset state; stall follows req even while in reset.
    reset = 1'b1;
    req = 4'b0101; rd = '0; wr = '0; addr = '0; wdata = '0;
    tick;
    chk("rst_stall", stall, 4'b0101);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    req = '0;
    tick;
    reset = 1'b0;

    // Single write then read by core 1.
    single(1, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF);
    single(1, 1'b1, 1'b0, 32'h80, 32'h0);
    chk("wr_rd_core1", rdata, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});

    // All four cores read at once from reset: served 0,1,2,3, 3 cycles each.
    do_reset;
    req = 4'hF; rd = 4'hF; wr = '0;
    addr = {4{32'h80}};
    for (int cyc = 0; cyc < 12; cyc++) begin
      s = cyc / 3;
      p = cyc % 3;
      #1;
      eg = (p == 0) ? 4'b0 : (4'b1 << s);
      es = 4'hF << s;
      if (p == 2) es[s] = 1'b0;
      chk("rr_grant", grant, eg);
      chk("rr_stall", stall, es);
      if (p == 2) begin
        req[s] = 1'b0;
        rd[s]  = 1'b0;
      end
      tick;
    end
    chk("rr_idle", busy, 0);
    chk("rr_rdata", rdata, {4{32'hDEADBEEF}});

    // After core 2 is served, cores 0 and 3 request together.
    do_reset;
    single(2, 1'b0, 1'b0, 32'h0, 32'h0);
    set_core(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_core(3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
`ifdef SHMEM_FIXED_PRIO_EN
    chk("rot_first", grant, 4'b0001);
    tick;
    req[0] = 1'b0;
    tick;
    tick;
    chk("rot_second", grant, 4'b1000);
    tick;
    req[3] = 1'b0;
`else
    chk("rot_first", grant, 4'b1000);
    tick;
    req[3] = 1'b0;
    tick;
    tick;
    chk("rot_second", grant, 4'b0001);
    tick;
    req[0] = 1'b0;
`endif
    tick;
    chk("rot_idle", busy, 0);

    // Address wrap modulo DEPTH, then a combined rd+wr access.
    single(0, 1'b0, 1'b1, 32'(4*D + 8), 32'h55);
    single(0, 1'b1, 1'b0, 32'h8, 32'h0);
    chk("wrap_read", rdata[DW-1:0], 32'h55);
    single(0, 1'b1, 1'b1, 32'h8, 32'h77);
    chk("rdwr_hold", rdata[DW-1:0], 32'h55);
    single(0, 1'b1, 1'b0, 32'h8, 32'h0);
    chk("rdwr_wrote", rdata[DW-1:0], 32'h77);

    // Reset during ACCESS drops the pending write and clears ptr.
    single(0, 1'b0, 1'b1, 32'h10, 32'h1111);
    set_core(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h1234);
    tick;
    chk("abort_grant", grant, 4'b0001);
    reset = 1'b1;
    req = '0; rd = '0; wr = '0;
    tick;
    reset = 1'b0;
    chk("abort_grant0", grant, 0);
    chk("abort_busy0", busy, 0);
    chk("abort_rdata0", rdata, 0);
    set_core(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    set_core(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    chk("abort_ptr0", grant, 4'b0001);
    tick;
    chk("abort_nowrite", rdata[DW-1:0], 32'h1111);
    set_core(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    tick;
    tick;
    chk("abort_next", grant, 4'b0010);
    tick;
    req[1] = 1'b0;
    tick;
    chk("end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
